// File: rtl/ace_ccu_sched.sv
// Round-robin scheduler for the shared CCU path: one ACE transaction at a time,
// grant held until the final R/B handshake, plus busy flag, counter and watchdog.
module ace_ccu_sched #(
  parameter int unsigned NoSlvPorts    = 4,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = 16,
  localparam int unsigned IdxWidth =
    (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NoSlvPorts-1:0] req_valid_i,
  input  logic [NoSlvPorts-1:0] req_is_write_i,
  input  logic                  ccu_ax_hs_i,
  input  logic                  ccu_w_last_hs_i,
  input  logic                  ccu_r_last_hs_i,
  input  logic                  ccu_b_hs_i,
  output logic [NoSlvPorts-1:0] gnt_o,
  output logic [IdxWidth-1:0]   gnt_idx_o,
  output logic                  busy_o,
  output logic [CntWidth-1:0]   txn_cnt_o,
  output logic                  timeout_o
);

  localparam int unsigned WdW =
    (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NoSlvPorts - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, RDATA, WDATA, BRESP
  } state_t;

  state_t              state, state_nxt;
  logic [IdxWidth-1:0] rr_ptr;
  logic                is_wr;
  logic                w_done, w_done_nxt;
  logic [WdW-1:0]      wdog, wdog_nxt;
  logic                found;
  logic [IdxWidth-1:0] win, idx;
  logic                hs, done;

  // Scan from rr_ptr upwards, wrapping; first requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NoSlvPorts; k++) begin
      idx = IdxWidth'((32'(rr_ptr) + k) % NoSlvPorts);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    w_done_nxt = w_done;
    hs         = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (found) state_nxt = ADDR;
      ADDR: begin
        if (ccu_ax_hs_i) begin
          hs = 1'b1;
          if (!is_wr)
            state_nxt = RDATA;
          else if (w_done || ccu_w_last_hs_i)
            state_nxt = BRESP;
          else
            state_nxt = WDATA;
        end else if (is_wr && ccu_w_last_hs_i) begin
          hs         = 1'b1;
          w_done_nxt = 1'b1;
        end
      end
      WDATA: if (ccu_w_last_hs_i) begin
        hs        = 1'b1;
        state_nxt = BRESP;
      end
      RDATA: if (ccu_r_last_hs_i) begin
        hs        = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      BRESP: if (ccu_b_hs_i) begin
        hs        = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog counts stalled busy cycles and saturates at the limit.
  always_comb begin
    wdog_nxt = wdog;
    if (TimeoutCycles == 0 || state_nxt == IDLE || hs)
      wdog_nxt = '0;
    else if (state != IDLE && wdog != WdMax)
      wdog_nxt = wdog + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      is_wr     <= 1'b0;
      w_done    <= 1'b0;
      wdog      <= '0;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      busy_o    <= 1'b0;
      txn_cnt_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      w_done    <= done ? 1'b0 : w_done_nxt;
      wdog      <= wdog_nxt;
      busy_o    <= (state_nxt != IDLE);
      timeout_o <= (TimeoutCycles != 0) && (wdog_nxt == WdMax) &&
                   (state_nxt != IDLE);
      if (state == IDLE && found) begin
        gnt_idx_o <= win;
        is_wr     <= req_is_write_i[win];
        gnt_o     <= NoSlvPorts'(1) << win;
      end
      if (done) begin
        gnt_o     <= '0;
        txn_cnt_o <= txn_cnt_o + 1'b1;
        rr_ptr    <= (gnt_idx_o == LastIdx) ? '0 : gnt_idx_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ace_ccu_sched.sv
// Directed bench for ace_ccu_sched: arbitration, write ordering,
// stray handshakes, watchdog and counter wrap.
module tb_ace_ccu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_is_write;
  logic       ax_hs, w_last_hs, r_last_hs, b_hs;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic [1:0] txn_cnt;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  ace_ccu_sched #(
    .NoSlvPorts    (4),
    .TimeoutCycles (8),
    .CntWidth      (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_is_write_i  (req_is_write),
    .ccu_ax_hs_i     (ax_hs),
    .ccu_w_last_hs_i (w_last_hs),
    .ccu_r_last_hs_i (r_last_hs),
    .ccu_b_hs_i      (b_hs),
    .gnt_o           (gnt),
    .gnt_idx_o       (gnt_idx),
    .busy_o          (busy),
    .txn_cnt_o       (txn_cnt),
    .timeout_o       (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ax, input logic w,
                       input logic r, input logic b);
    ax_hs = ax; w_last_hs = w; r_last_hs = r; b_hs = b;
    step();
    ax_hs = 0; w_last_hs = 0; r_last_hs = 0; b_hs = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] rr_gnt [3] = '{4'b0010, 4'b1000, 4'b0010};
  logic [1:0] rr_idx [3] = '{2'd1, 2'd3, 2'd1};
  logic [1:0] wrap   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rst = 1'b1;
    req_valid = 4'b1111;
    req_is_write = 4'b0000;
    ax_hs = 0; w_last_hs = 0; r_last_hs = 0; b_hs = 0;

    // Reset with all ports requesting
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", 32'(txn_cnt), 32'h0);
    chk("rst_tmo", 32'(timeout), 32'h0);
    step();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_busy", 32'(busy), 32'h1);
    req_valid = 4'b0000;
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    chk("first_done_busy", 32'(busy), 32'h0);
    chk("first_done_cnt", 32'(txn_cnt), 32'h1);
    pulse(0, 0, 0, 1);
    chk("idle_stray_busy", 32'(busy), 32'h0);
    chk("idle_stray_cnt", 32'(txn_cnt), 32'h1);

    // Round-robin between ports 1 and 3
    do_reset();
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(rr_gnt[i]));
      chk("rr_idx", 32'(gnt_idx), 32'(rr_idx[i]));
      pulse(1, 0, 0, 0);
      chk("rr_hold", 32'(gnt), 32'(rr_gnt[i]));
      pulse(0, 0, 1, 0);
      chk("rr_release", 32'(gnt), 32'h0);
    end
    req_valid = 4'b0000;
    chk("rr_cnt", 32'(txn_cnt), 32'h3);
    step();
    chk("idle_keep_idx", 32'(gnt_idx), 32'h1);
    chk("idle_no_gnt", 32'(gnt), 32'h0);

    // Write with W last before AW, stray R last in BRESP
    do_reset();
    req_valid = 4'b0100;
    req_is_write = 4'b0100;
    step();
    chk("wr_gnt", 32'(gnt), 32'h4);
    req_valid = 4'b0000;
    pulse(0, 1, 0, 0);
    step();
    step();
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    chk("bresp_stray_r", 32'(busy), 32'h1);
    pulse(0, 0, 0, 1);
    chk("wr_done_busy", 32'(busy), 32'h0);
    chk("wr_done_cnt", 32'(txn_cnt), 32'h1);

    // Same-cycle AW and W last, then rr_ptr points at port 3
    do_reset();
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    pulse(1, 1, 0, 0);
    chk("same_cyc_busy", 32'(busy), 32'h1);
    pulse(0, 0, 0, 1);
    chk("same_cyc_done", 32'(busy), 32'h0);
    req_valid = 4'b1111;
    req_is_write = 4'b0000;
    step();
    req_valid = 4'b0000;
    chk("rr_ptr3_gnt", 32'(gnt), 32'h8);
    chk("rr_ptr3_idx", 32'(gnt_idx), 32'h3);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    chk("rr_ptr3_cnt", 32'(txn_cnt), 32'h2);

    // Watchdog: stall in ADDR, then in RDATA
    do_reset();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    for (int i = 0; i < 7; i++) step();
    chk("wdog_pre", 32'(timeout), 32'h0);
    step();
    chk("wdog_hit", 32'(timeout), 32'h1);
    step();
    step();
    chk("wdog_sat", 32'(timeout), 32'h1);
    pulse(1, 0, 0, 0);
    chk("wdog_clr", 32'(timeout), 32'h0);
    for (int i = 0; i < 7; i++) step();
    chk("wdog_pre2", 32'(timeout), 32'h0);
    step();
    chk("wdog_hit2", 32'(timeout), 32'h1);
    pulse(0, 0, 1, 0);
    chk("wdog_idle", 32'(timeout), 32'h0);
    chk("wdog_idle_busy", 32'(busy), 32'h0);

    // Counter wrap at 2 bits
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      chk("cnt_wrap", 32'(txn_cnt), 32'(wrap[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
